// File: rtl/rx_deframer.sv
// rx_deframer: rebuilds 2*W-bit I/Q samples from the W-bit receive word stream.
// A frame is four words: I high (frame=1), Q high (frame=1), I low (frame=0), Q low (frame=0).
// A lock FSM (HUNT/SYNC/LOCKED) checks the frame pattern and only complete frames whose
// first word was taken while LOCKED reach i_out/q_out.
module rx_deframer #(
  parameter int W           = 6,
  parameter int LOCK_FRAMES = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             rx_frame,
  input  logic [W-1:0]     rx_d,
  input  logic             clr_err,
  output logic [2*W-1:0]   i_out,
  output logic [2*W-1:0]   q_out,
  output logic             iq_valid,
  output logic             locked,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_phase;
  logic [1:0]    w_phase_nx;
  logic [GW-1:0] r_good_cnt;
  logic [GW-1:0] w_good_nx;
  logic          r_prev_frame;
  logic          r_w0_lk;
  logic          w_w0_lk_nx;
  logic [W-1:0]  r_i_hi;
  logic [W-1:0]  r_q_hi;
  logic [W-1:0]  r_i_lo;

  logic w_start;
  logic w_good;
  logic w_ld_i_hi;
  logic w_ld_q_hi;
  logic w_ld_i_lo;
  logic w_emit;
  logic w_err;

  // A start is a 0->1 frame edge; phases 0,1 expect frame=1, phases 2,3 expect frame=0.
  assign w_start = rx_frame & ~r_prev_frame;
  assign w_good  = (rx_frame == ~r_phase[1]);
  assign locked  = (r_state == LOCKED);

  // Next-state and datapath control for the lock FSM.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_good_nx  = r_good_cnt;
    w_w0_lk_nx = r_w0_lk;
    w_ld_i_hi  = 1'b0;
    w_ld_q_hi  = 1'b0;
    w_ld_i_lo  = 1'b0;
    w_emit     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      HUNT: begin
        w_w0_lk_nx = 1'b0;
        if (w_start) begin
          w_ld_i_hi  = 1'b1;
          w_phase_nx = 2'd1;
          w_good_nx  = '0;
          w_state_nx = SYNC;
        end
      end
      SYNC, LOCKED: begin
        if (!w_good) begin
          // SYNC and LOCKED share the mismatch path; only LOCKED reports it.
          w_err      = (r_state == LOCKED);
          w_w0_lk_nx = 1'b0;
          if (w_start) begin
            w_ld_i_hi  = 1'b1;
            w_phase_nx = 2'd1;
            w_good_nx  = '0;
            w_state_nx = SYNC;
          end else begin
            w_phase_nx = 2'd0;
            w_state_nx = HUNT;
          end
        end else begin
          w_phase_nx = r_phase + 2'd1;
          w_ld_i_hi  = (r_phase == 2'd0);
          w_ld_q_hi  = (r_phase == 2'd1);
          w_ld_i_lo  = (r_phase == 2'd2);
          if (r_state == LOCKED) begin
            if (r_phase == 2'd0) begin
              w_w0_lk_nx = 1'b1;
            end
            if (r_phase == 2'd3) begin
              w_emit     = r_w0_lk;
              w_w0_lk_nx = 1'b0;
            end
          end else if (r_phase == 2'd3) begin
            if (r_good_cnt == GW'(LOCK_FRAMES - 1)) begin
              w_good_nx  = '0;
              w_state_nx = LOCKED;
            end else begin
              w_good_nx = r_good_cnt + GW'(1);
            end
          end
        end
      end
      default: begin
        w_state_nx = HUNT;
        w_phase_nx = 2'd0;
        w_good_nx  = '0;
        w_w0_lk_nx = 1'b0;
      end
    endcase
  end

  // FSM state, word phase, good-frame count and frame-edge history.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= HUNT;
      r_phase      <= 2'd0;
      r_good_cnt   <= '0;
      r_w0_lk      <= 1'b0;
      r_prev_frame <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_phase      <= w_phase_nx;
      r_good_cnt   <= w_good_nx;
      r_w0_lk      <= w_w0_lk_nx;
      r_prev_frame <= rx_frame;
    end
  end

  // Holding registers for the first three words of the frame in progress.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_i_hi <= '0;
      r_q_hi <= '0;
      r_i_lo <= '0;
    end else begin
      if (w_ld_i_hi) r_i_hi <= rx_d;
      if (w_ld_q_hi) r_q_hi <= rx_d;
      if (w_ld_i_lo) r_i_lo <= rx_d;
    end
  end

  // Sample outputs: updated only on a complete locked frame, held otherwise.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      i_out    <= '0;
      q_out    <= '0;
      iq_valid <= 1'b0;
    end else begin
      iq_valid <= w_emit;
      if (w_emit) begin
        i_out <= {r_i_hi, r_i_lo};
        q_out <= {r_q_hi, rx_d};
      end
    end
  end

  // Error pulse and saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= w_err;
      if (clr_err) begin
        err_cnt <= '0;
      end else if (w_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: frame table applied in a loop, expected strobes and
// error pulses queued at drive time and matched by a negedge monitor.
module tb_rx_deframer;

  logic        clk      = 1'b0;
  logic        reset_b  = 1'b1;
  logic        rx_frame = 1'b0;
  logic        clr_err  = 1'b0;
  logic [5:0]  rx_d     = '0;
  logic [11:0] i_out, q_out;
  logic        iq_valid, locked, frame_err;
  logic [15:0] err_cnt;
  logic [11:0] i4, q4;
  logic        v4, l4, fe4;
  logic [3:0]  ec4;

  rx_deframer #(.W(6), .LOCK_FRAMES(4), .ERR_W(16)) u_dut (
    .clk(clk), .reset_b(reset_b), .rx_frame(rx_frame), .rx_d(rx_d), .clr_err(clr_err),
    .i_out(i_out), .q_out(q_out), .iq_valid(iq_valid), .locked(locked),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  rx_deframer #(.W(6), .LOCK_FRAMES(4), .ERR_W(4)) u_dut4 (
    .clk(clk), .reset_b(reset_b), .rx_frame(rx_frame), .rx_d(rx_d), .clr_err(clr_err),
    .i_out(i4), .q_out(q4), .iq_valid(v4), .locked(l4),
    .frame_err(fe4), .err_cnt(ec4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int K_OK    = 0;  // clean frame
  localparam int K_GL    = 1;  // W1 driven with frame=0
  localparam int K_GLCLR = 2;  // as K_GL, with clr_err on the bad word
  localparam int K_TRUNC = 3;  // only W0..W2 sent
  localparam int K_EARLY = 4;  // W0 lands where W3 was expected

  typedef struct {
    int unsigned cyc;
    logic [11:0] i;
    logic [11:0] q;
  } exp_t;

  typedef struct {
    logic [11:0] i;
    logic [11:0] q;
    int          kind;
    bit          lk;   // locked expected just before W0 is driven
    bit          out;  // frame must produce a strobe
  } frm_t;

  exp_t        iq_q[$];
  int unsigned err_q[$];
  frm_t        tbl[$];
  int          exp_err  = 0;
  int          exp_err4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(input logic [11:0] i, input logic [11:0] q, input int kind,
                              input bit lk, input bit out);
    frm_t f;
    f.i = i; f.q = q; f.kind = kind; f.lk = lk; f.out = out;
    tbl.push_back(f);
  endfunction

  // Monitor: every strobe and error pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    int unsigned ec;
    if (iq_valid) begin
      if (iq_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_iq_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = iq_q.pop_front();
        chk("iq_valid_cycle", cyc, e.cyc);
        chk("i_out", i_out, e.i);
        chk("q_out", q_out, e.q);
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_frame_err: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        ec = err_q.pop_front();
        chk("frame_err_cycle", cyc, ec);
      end
    end
  end

  task automatic send_word(input logic f, input logic [5:0] d);
    @(negedge clk);
    rx_frame = f;
    rx_d     = d;
  endtask

  task automatic send_frame(input frm_t fr);
    logic [11:0] i;
    logic [11:0] q;
    exp_t e;
    i = fr.i;
    q = fr.q;
    @(negedge clk);
    chk("locked", locked, fr.lk);
    rx_frame = 1'b1;
    rx_d     = i[11:6];
    if (fr.kind == K_EARLY) err_q.push_back(cyc + 1);
    if (fr.kind == K_GL || fr.kind == K_GLCLR) begin
      send_word(1'b0, q[11:6]);
      err_q.push_back(cyc + 1);
      if (fr.kind == K_GLCLR) clr_err = 1'b1;
    end else begin
      send_word(1'b1, q[11:6]);
    end
    send_word(1'b0, i[5:0]);
    clr_err = 1'b0;
    if (fr.kind != K_TRUNC) begin
      send_word(1'b0, q[5:0]);
      if (fr.out) begin
        e.cyc = cyc + 1; e.i = i; e.q = q;
        iq_q.push_back(e);
      end
    end
    if (fr.kind == K_GL || fr.kind == K_EARLY) begin
      exp_err++;
      exp_err4 = (exp_err4 < 15) ? exp_err4 + 1 : 15;
    end else if (fr.kind == K_GLCLR) begin
      exp_err  = 0;
      exp_err4 = 0;
    end
    chk("err_cnt", err_cnt, exp_err);
    chk("err_cnt_w4", ec4, exp_err4);
  endtask

  task automatic run(input int a, input int b);
    for (int k = a; k < b; k++) send_frame(tbl[k]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_out"}, i_out, 0);
    chk({tag, "_q_out"}, q_out, 0);
    chk({tag, "_iq_valid"}, iq_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_err_cnt_w4"}, ec4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s2_end, s4_end, s5_end;

    // Lock, output and glitch recovery on a continuous stream.
    add(12'h123, 12'hABC, K_OK, 0, 0);
    add(12'h7FF, 12'h800, K_OK, 0, 0);
    add(12'h000, 12'hFFF, K_OK, 0, 0);
    add(12'h555, 12'h2AA, K_OK, 0, 0);
    add(12'h123, 12'hABC, K_OK, 1, 1);
    add(12'h800, 12'h7FF, K_OK, 1, 1);
    add(12'hFFF, 12'h001, K_GL, 1, 0);
    for (int k = 0; k < 4; k++) add(12'h3C3, 12'hC3C, K_OK, 0, 0);
    add(12'hFFF, 12'h000, K_OK, 1, 1);
    add(12'h001, 12'hFFE, K_OK, 1, 1);
    s2_end = tbl.size();
    // Start after reset with frame held high through a discarded frame.
    for (int k = 0; k < 4; k++) add(12'h123, 12'hABC, K_OK, 0, 0);
    add(12'h123, 12'hABC, K_OK, 1, 1);
    add(12'hA5A, 12'h5A5, K_OK, 1, 1);
    s4_end = tbl.size();
    // Repeated errors to saturate the narrow counter, then clear on an error cycle.
    for (int n = 0; n < 20; n++) begin
      add(12'h0F0, 12'hF0F, K_GL, 1, 0);
      for (int k = 0; k < 4; k++) add(12'h111, 12'h222, K_OK, 0, 0);
    end
    add(12'h0F0, 12'hF0F, K_GLCLR, 1, 0);
    for (int k = 0; k < 4; k++) add(12'h333, 12'h444, K_OK, 0, 0);
    s5_end = tbl.size();
    // Early frame edge while locked resynchronises straight into SYNC.
    add(12'h456, 12'hBA9, K_OK, 1, 1);
    add(12'h777, 12'h888, K_TRUNC, 1, 0);
    add(12'h135, 12'h9BD, K_EARLY, 1, 0);
    for (int k = 0; k < 3; k++) add(12'h246, 12'h8AC, K_OK, 0, 0);
    add(12'h6E2, 12'h1F7, K_OK, 1, 1);
    add(12'h800, 12'h801, K_OK, 1, 1);

    // Reset with random inputs.
    #1 reset_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx_frame = 1'($urandom);
      rx_d     = 6'($urandom);
      clr_err  = 1'($urandom);
      #1 chk_zero("reset");
    end
    @(negedge clk);
    reset_b  = 1'b1;
    clr_err  = 1'b0;
    rx_frame = 1'b0;
    rx_d     = '0;
    run(0, s2_end);

    // Async reset in the middle of a locked frame.
    send_word(1'b1, 6'h11);
    send_word(1'b1, 6'h22);
    @(negedge clk);
    #2 reset_b = 1'b0;
    #1 chk_zero("async_reset");
    chk("pending_iq", iq_q.size(), 0);
    exp_err  = 0;
    exp_err4 = 0;
    rx_frame = 1'b1;
    rx_d     = '0;
    @(negedge clk);
    @(negedge clk);
    reset_b  = 1'b1;
    rx_d     = 6'h3F;
    send_word(1'b1, 6'h15);
    send_word(1'b0, 6'h2A);
    send_word(1'b0, 6'h07);
    run(s2_end, s4_end);

    run(s4_end, s5_end);
    run(s5_end, tbl.size());

    @(negedge clk);
    #2;
    chk("iq_queue_empty", iq_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
